// File: rtl/b16_adder.sv
// b16_adder: 16-bit unsigned adder with registered sum and carry-out.
// Two cascaded 8-bit ripple-carry slices feed a reset-clean output register.
module b16_adder (
   output logic [15:0] S,
   output logic        C,
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic        clk,
   input  logic        rst_n
);

   logic [7:0]  w_sum_lo;
   logic [7:0]  w_sum_hi;
   logic        w_cout_lo;
   logic        w_cout_hi;
   logic [15:0] r_sum;
   logic        r_carry;

   // Low byte: no carry-in port exists, so the chain starts at zero.
   b16_slice8 u_slice_lo (
      .sum  (w_sum_lo),
      .cout (w_cout_lo),
      .a    (A[7:0]),
      .b    (B[7:0]),
      .cin  (1'b0)
   );

   // High byte: carry crosses the byte boundary from the low slice.
   b16_slice8 u_slice_hi (
      .sum  (w_sum_hi),
      .cout (w_cout_hi),
      .a    (A[15:8]),
      .b    (B[15:8]),
      .cin  (w_cout_lo)
   );

   // Capture the 17-bit combinational result; reset clears it immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum   <= '0;
         r_carry <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values, avoiding ordering races.
         r_sum   <= {w_sum_hi, w_sum_lo};
         r_carry <= w_cout_hi;
      end
   end

   assign S = r_sum;
   assign C = r_carry;

endmodule

// b16_slice8: eight full adders chained LSB to MSB.
module b16_slice8 (
   output logic [7:0] sum,
   output logic       cout,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin
);

   logic [8:0] w_carry;

   assign w_carry[0] = cin;

   for (genvar i = 0; i < 8; i++) begin : g_bit
      b16_fa u_fa (
         .s  (sum[i]),
         .co (w_carry[i+1]),
         .a  (a[i]),
         .b  (b[i]),
         .ci (w_carry[i])
      );
   end

   assign cout = w_carry[8];

endmodule

// b16_fa: 1-bit full adder.
module b16_fa (
   output logic s,
   output logic co,
   input  logic a,
   input  logic b,
   input  logic ci
);

   logic w_p;

   // Propagate term shared by the sum and the carry.
   assign w_p = a ^ b;
   assign s   = w_p ^ ci;
   assign co  = (a & b) | (ci & w_p);

endmodule

// File: tb/tb_b16_adder.sv
// tb_b16_adder: scoreboard bench for b16_adder with a plain-arithmetic reference.
module tb_b16_adder;

   logic [15:0] S;
   logic        C;
   logic [15:0] A;
   logic [15:0] B;
   logic        clk;
   logic        rst_n;

   logic [16:0] exp_q[$];
   int          n_checks;
   int          n_fail;

   b16_adder dut (
      .S     (S),
      .C     (C),
      .A     (A),
      .B     (B),
      .clk   (clk),
      .rst_n (rst_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: unsigned 17-bit sum, carry in bit 16.
   function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one operand pair between edges and record its expected result.
   task automatic apply(input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      A = a;
      B = b;
      exp_q.push_back(ref_add(a, b));
   endtask

   // Monitor: each pending result must be visible right after the next edge.
   initial begin
      logic [16:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("scoreboard", {C, S}, e);
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] ra;
      logic [15:0] rb;
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      A        = 16'h1234;
      B        = 16'h1111;

      // Held in reset: outputs stay clear across several edges.
      repeat (3) begin
         @(posedge clk);
         #1;
         check("reset_hold", {C, S}, 17'h0_0000);
      end

      // Release; first edge loads 0x1234 + 0x1111.
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(ref_add(16'h1234, 16'h1111));

      // Basic, wrap-around and byte-boundary cases.
      apply(16'h0000, 16'h0000);
      apply(16'h0003, 16'h0004);
      apply(16'h0300, 16'h0400);
      apply(16'h0003, 16'hFFFF);
      apply(16'hFFFF, 16'hFFFF);
      apply(16'h00FF, 16'h0001);
      apply(16'h80FF, 16'h8001);
      apply(16'hFFFF, 16'h0001);
      apply(16'h7FFF, 16'h8000);

      // Mid-stream reset: clears without waiting for an edge.
      apply(16'h1000, 16'h2000);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_clear", {C, S}, 17'h0_0000);
      @(negedge clk);
      A = 16'h4321;
      B = 16'h1111;
      @(posedge clk);
      #1;
      check("reset_discard", {C, S}, 17'h0_0000);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(ref_add(16'h4321, 16'h1111));

      // Random regression.
      for (int i = 0; i < 10000; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         apply(ra, rb);
      end

      // Drain with a bounded wait.
      for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
      #2;
      check("drain", 17'(exp_q.size()), 17'h0_0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/b16_adder.md
# b16_adder

16-bit unsigned binary adder with registered outputs. It adds two 16-bit operands and produces a 16-bit sum plus a carry-out. Internally it is two cascaded 8-bit ripple-carry slices, each built from eight 1-bit full adders. It serves as the basic arithmetic building block for datapaths that need a synchronous, reset-clean add result.

## Interface
Parameters: none; all widths are fixed at 16 bits.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock for the output registers
- rst_n  input  1  asynchronous active-low reset; clears the output registers
- S  output  16  registered sum, (A + B) mod 2^16
- C  output  1  registered carry-out, bit 16 of A + B
- A  input  16  operand A, unsigned
- B  input  16  operand B, unsigned

Positional port order is S, C, A, B, followed by clk, rst_n. Instances should connect by name.

## Operation
Structure:
- 1-bit full adder: s = a ^ b ^ ci; co = (a & b) | (ci & (a ^ b)).
- 8-bit slice: eight full adders chained LSB to MSB; ports are sum[7:0], cout, a[7:0], b[7:0], cin.
- Low slice: A[7:0] + B[7:0] with cin = 0.
- High slice: A[15:8] + B[15:8] with cin = cout of the low slice.
- The combinational result {cout_hi, sum_hi, sum_lo} is 17 bits and is captured into the S and C registers.

Arithmetic rules:
- Unsigned only. There is no overflow flag beyond C, and no carry-in port.
- Wrap-around: a sum of 2^16 or more sets C = 1, and S holds the low 16 bits.
- The carry must propagate across the byte boundary through the internal slice-to-slice carry, e.g. 0x00FF + 0x0001 → 0x0100.

Reset:
- While rst_n = 0, S = 0x0000 and C = 0, regardless of clk or the inputs.
- After rst_n is deasserted, the first rising clk edge loads the current sum.

## Timing
- Latency is 1 cycle. Inputs sampled at rising edge n appear on S and C after edge n and hold until edge n+1.
- Throughput is 1 add per cycle. There is no handshake and no stall; A and B may change every cycle.
- The combinational path from A/B to the register D-inputs is a 16-stage ripple. This is acceptable at the target clock.
- Reset assertion takes effect immediately and asynchronously, including mid-stream, and the in-flight result is discarded.
- Reset deassertion is sampled synchronously: the first capture happens on the first rising edge with rst_n = 1.
- If rst_n rises at the same edge as a capture, the outputs stay 0 for that edge.
- X or Z on A or B produces an undefined S/C only for the cycle in which that input was sampled.

## Test plan
- Reset: hold rst_n = 0 with A = 0x1234, B = 0x1111 and toggle clk → S = 0x0000, C = 0 throughout. Release reset; after 1 edge → S = 0x2345, C = 0.
- Basic adds, one per cycle:
  - 0x0000 + 0x0000 → 0x0000, C = 0
  - 0x0003 + 0x0004 → 0x0007, C = 0
  - 0x0300 + 0x0400 → 0x0700, C = 0
  - Each result must appear exactly 1 cycle after its inputs are applied.
- Wrap-around: 0x0003 + 0xFFFF → S = 0x0002, C = 1. Also 0xFFFF + 0xFFFF → S = 0xFFFE, C = 1.
- Byte-boundary carry: 0x00FF + 0x0001 → S = 0x0100, C = 0. Also 0x80FF + 0x8001 → S = 0x0100, C = 1.
- Mid-stream reset: stream 0x1000 + 0x2000, then assert rst_n = 0 between clock edges → S and C clear to 0 immediately, without waiting for a clock edge.
- Random regression: at least 10,000 random A/B pairs, each compared against the 17-bit reference A + B delayed by 1 cycle.
